// File: rtl/real_to_pwl.sv
// Fixed-point real-to-PWL converter: ramps out toward each new sample in 2**TR_LOG2 clocks.
// Ports: clk, rstn, in (target), out (value), slope (per-cycle step), busy, seg_start, settled.
module real_to_pwl #(
    parameter int W       = 16,
    parameter int TR_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic signed [W-1:0] in,
    output logic signed [W-1:0] out,
    output logic signed [W:0]   slope,
    output logic                busy,
    output logic                seg_start,
    output logic                settled
);

    localparam int CW = TR_LOG2 + 1;
    localparam logic [CW-1:0] N = CW'(1 << TR_LOG2);

    typedef enum logic {
        S_IDLE,
        S_RAMP
    } state_t;

    state_t               state, state_n;
    logic signed [W-1:0]  target, target_n;
    logic signed [W-1:0]  out_n;
    logic signed [W:0]    slope_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 seg_n, set_n;

    logic                 change;
    logic signed [W:0]    diff;
    logic [W:0]           mag;
    logic [W:0]           step_mag;
    logic signed [W:0]    new_slope;
    logic signed [W:0]    ramp_sum;

    assign change = (in != target);

    // W+1 bits holds any difference of two W-bit values, so full-scale steps
    // never wrap; magnitude is shifted so the ramp truncates toward zero.
    assign diff      = {in[W-1], in} - {out[W-1], out};
    assign mag       = diff[W] ? $unsigned(-diff) : $unsigned(diff);
    assign step_mag  = mag >> TR_LOG2;
    assign new_slope = diff[W] ? -$signed(step_mag) : $signed(step_mag);
    assign ramp_sum  = {out[W-1], out} + slope;

    assign busy = (state == S_RAMP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            target    <= '0;
            out       <= '0;
            slope     <= '0;
            cnt       <= '0;
            seg_start <= 1'b0;
            settled   <= 1'b0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            out       <= out_n;
            slope     <= slope_n;
            cnt       <= cnt_n;
            seg_start <= seg_n;
            settled   <= set_n;
        end
    end

    // A change always wins: retargeting restarts from the current out
    // without applying the old increment on that edge.
    always_comb begin
        state_n  = state;
        target_n = target;
        out_n    = out;
        slope_n  = slope;
        cnt_n    = cnt;
        seg_n    = 1'b0;
        set_n    = 1'b0;
        priority case (1'b1)
            change: begin
                state_n  = S_RAMP;
                target_n = in;
                slope_n  = new_slope;
                cnt_n    = N;
                seg_n    = 1'b1;
            end
            (state == S_RAMP) && (cnt == CW'(1)): begin
                state_n = S_IDLE;
                out_n   = target;
                slope_n = '0;
                cnt_n   = '0;
                set_n   = 1'b1;
            end
            (state == S_RAMP): begin
                out_n = ramp_sum[W-1:0];
                cnt_n = cnt - CW'(1);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_real_to_pwl.sv
// Self-checking bench for real_to_pwl: directed tables plus random stimulus
// against a segment-level model; instances at TR_LOG2=2 and TR_LOG2=0.
module tb_real_to_pwl;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic signed [15:0] in0 = '0, in1 = '0;
    logic signed [15:0] out0, out1;
    logic signed [16:0] slope0, slope1;
    logic busy0, busy1, ss0, ss1, st0, st1;

    always #5 clk = ~clk;

    real_to_pwl #(.W(16), .TR_LOG2(2)) u0 (
        .clk(clk), .rstn(rstn), .in(in0), .out(out0), .slope(slope0),
        .busy(busy0), .seg_start(ss0), .settled(st0)
    );

    real_to_pwl #(.W(16), .TR_LOG2(0)) u1 (
        .clk(clk), .rstn(rstn), .in(in1), .out(out1), .slope(slope1),
        .busy(busy1), .seg_start(ss1), .settled(st1)
    );

    int total = 0;
    int bad = 0;

    int lg[2] = '{2, 0};
    int m_out[2], m_tgt[2], m_slope[2], m_start[2], m_k[2];
    int m_busy[2], m_ss[2], m_st[2];

    typedef struct {
        int in;
        int out;
        int slope;
        int busy;
        int ss;
        int st;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 0; m_tgt[i] = 0; m_slope[i] = 0; m_start[i] = 0;
            m_k[i] = 0; m_busy[i] = 0; m_ss[i] = 0; m_st[i] = 0;
        end
    endtask

    // Segment view: out = start + k*slope, forced to the target on step N.
    task automatic model_step(input int i, input int v);
        int d, mag, n;
        n = 1 << lg[i];
        m_ss[i] = 0;
        m_st[i] = 0;
        if (v != m_tgt[i]) begin
            d = v - m_out[i];
            mag = ((d < 0) ? -d : d) >> lg[i];
            m_slope[i] = (d < 0) ? -mag : mag;
            m_start[i] = m_out[i];
            m_tgt[i] = v;
            m_k[i] = 0;
            m_busy[i] = 1;
            m_ss[i] = 1;
        end else if (m_busy[i] != 0) begin
            m_k[i]++;
            if (m_k[i] == n) begin
                m_out[i] = m_tgt[i];
                m_slope[i] = 0;
                m_busy[i] = 0;
                m_st[i] = 1;
            end else begin
                m_out[i] = m_start[i] + m_k[i] * m_slope[i];
            end
        end
    endtask

    task automatic compare_all();
        check("u0.out", int'(out0), m_out[0]);
        check("u0.slope", int'(slope0), m_slope[0]);
        check("u0.busy", int'(busy0), m_busy[0]);
        check("u0.seg_start", int'(ss0), m_ss[0]);
        check("u0.settled", int'(st0), m_st[0]);
        check("u1.out", int'(out1), m_out[1]);
        check("u1.slope", int'(slope1), m_slope[1]);
        check("u1.busy", int'(busy1), m_busy[1]);
        check("u1.seg_start", int'(ss1), m_ss[1]);
        check("u1.settled", int'(st1), m_st[1]);
    endtask

    task automatic tick();
        model_step(0, int'(in0));
        model_step(1, int'(in1));
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Assert reset away from any edge, check the async clear, release at negedge.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        check("rst.out0", int'(out0), 0);
        check("rst.busy0", int'(busy0), 0);
        check("rst.slope0", int'(slope0), 0);
        check("rst.ss0", int'(ss0), 0);
        check("rst.out1", int'(out1), 0);
        check("rst.busy1", int'(busy1), 0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic pick(inout logic signed [15:0] v);
        case ($urandom_range(0, 3))
            0: v = 16'($urandom);
            1: v = 16'(int'(v) + int'($urandom_range(0, 6)) - 3);
            2: v = ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000;
            default: v = 16'($urandom_range(0, 2000));
        endcase
    endtask

    initial begin
        // test 2, 3, |d|<N, test 4, full-scale, all on the TR_LOG2=2 instance
        tbl.push_back('{1000, 0, 250, 1, 1, 0});
        tbl.push_back('{1000, 250, 250, 1, 0, 0});
        tbl.push_back('{1000, 500, 250, 1, 0, 0});
        tbl.push_back('{1000, 750, 250, 1, 0, 0});
        tbl.push_back('{1000, 1000, 0, 0, 0, 1});
        tbl.push_back('{1000, 1000, 0, 0, 0, 0});
        tbl.push_back('{-1, 1000, -250, 1, 1, 0});
        tbl.push_back('{-1, 750, -250, 1, 0, 0});
        tbl.push_back('{-1, 500, -250, 1, 0, 0});
        tbl.push_back('{-1, 250, -250, 1, 0, 0});
        tbl.push_back('{-1, -1, 0, 0, 0, 1});
        tbl.push_back('{0, -1, 0, 1, 1, 0});
        tbl.push_back('{0, -1, 0, 1, 0, 0});
        tbl.push_back('{0, -1, 0, 1, 0, 0});
        tbl.push_back('{0, -1, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1});
        tbl.push_back('{1000, 0, 250, 1, 1, 0});
        tbl.push_back('{1000, 250, 250, 1, 0, 0});
        tbl.push_back('{1000, 500, 250, 1, 0, 0});
        tbl.push_back('{0, 500, -125, 1, 1, 0});
        tbl.push_back('{0, 375, -125, 1, 0, 0});
        tbl.push_back('{0, 250, -125, 1, 0, 0});
        tbl.push_back('{0, 125, -125, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1});
        tbl.push_back('{-32768, 0, -8192, 1, 1, 0});
        tbl.push_back('{-32768, -8192, -8192, 1, 0, 0});
        tbl.push_back('{-32768, -16384, -8192, 1, 0, 0});
        tbl.push_back('{-32768, -24576, -8192, 1, 0, 0});
        tbl.push_back('{-32768, -32768, 0, 0, 0, 1});
        tbl.push_back('{32767, -32768, 16383, 1, 1, 0});
        tbl.push_back('{32767, -16385, 16383, 1, 0, 0});
        tbl.push_back('{32767, -2, 16383, 1, 0, 0});
        tbl.push_back('{32767, 16381, 16383, 1, 0, 0});
        tbl.push_back('{32767, 32767, 0, 0, 0, 1});

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("init.out0", int'(out0), 0);
        check("init.busy0", int'(busy0), 0);
        check("init.settled0", int'(st0), 0);
        @(negedge clk);
        rstn = 1'b1;

        // test 1: idle with in=0
        repeat (20) tick();

        foreach (tbl[j]) begin
            in0 = 16'(tbl[j].in);
            tick();
            check($sformatf("tbl%0d.out", j), int'(out0), tbl[j].out);
            check($sformatf("tbl%0d.slope", j), int'(slope0), tbl[j].slope);
            check($sformatf("tbl%0d.busy", j), int'(busy0), tbl[j].busy);
            check($sformatf("tbl%0d.ss", j), int'(ss0), tbl[j].ss);
            check($sformatf("tbl%0d.st", j), int'(st0), tbl[j].st);
        end

        in0 = 16'sd0;
        repeat (5) tick();
        check("back0.out0", int'(out0), 0);

        // test 5: reset at E2 of a ramp, then a fresh ramp with in held
        in0 = 16'sd1000;
        repeat (3) tick();
        check("pre_rst.out0", int'(out0), 500);
        do_reset();
        tick();
        check("post_rst.ss0", int'(ss0), 1);
        check("post_rst.slope0", int'(slope0), 250);
        repeat (4) tick();
        check("post_rst.out0", int'(out0), 1000);
        check("post_rst.st0", int'(st0), 1);

        // test 6: one-cycle step on the TR_LOG2=0 instance
        in1 = -16'sd32768;
        tick();
        check("t6.e0.out1", int'(out1), 0);
        check("t6.e0.slope1", int'(slope1), -32768);
        tick();
        check("t6.e1.out1", int'(out1), -32768);
        check("t6.e1.st1", int'(st1), 1);
        check("t6.e1.busy1", int'(busy1), 0);
        in1 = 16'sh7fff;
        tick();
        check("fs.slope1", int'(slope1), 65535);
        tick();
        check("fs.out1", int'(out1), 32767);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) pick(in0);
            if ($urandom_range(0, 3) == 0) pick(in1);
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
            if (ss0 && st0) check("excl0", 1, 0);
            if (ss1 && st1) check("excl1", 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
